ysyx_23060025_wb_arbiter: RTL and testbench
===========================================

// Module: ysyx_23060025_wb_arbiter
// PURPOSE
//  Shares the single writeback port (GPR write plus CSR write) between two result producers:
//  requester 0 is the EXU fast path and requester 1 is the LSU/multi-cycle path.
//  Arbitrates round-robin and registers the winner into a 1-entry output stage.
//  Feeds the wb stage through a valid/ready handshake.
//  Halts all further writeback once an ebreak packet has retired.
// PARAMETERS
//  DATA_LEN  32  width of GPR/CSR write data
// PORTS
//  clock            in   1         single clock; all state on posedge
//  reset            in   1         asynchronous, active-low reset
//  rN_valid_i       in   1         (N=0,1) requester N has a packet
//  rN_ready_o       out  1         packet N accepted this cycle (valid&ready)
//  rN_wd_i          in   1         GPR write enable
//  rN_wreg_i        in   5         GPR index
//  rN_wdata_i       in   DATA_LEN  GPR write data
//  rN_csr_type_i    in   3         CSR op type (0 = none)
//  rN_csr_waddr_i   in   12        CSR address
//  rN_csr_wdata_i   in   DATA_LEN  CSR write data
//  rN_ebreak_i      in   1         packet is an ebreak
//  out_valid_o      out  1         output stage holds a packet
//  wbu_ready_i      in   1         wb stage consumes the packet
//  wd_o             out  1         GPR write enable (forced 0 when wreg_o==0)
//  wreg_o           out  5         GPR index
//  wdata_o          out  DATA_LEN  GPR write data
//  csr_type_o       out  3         CSR op type
//  csr_waddr_o      out  12        CSR address
//  csr_wdata_o      out  DATA_LEN  CSR write data
//  ebreak_o         out  1         held packet is an ebreak
//  grant_o          out  1         id of the requester whose packet is held
//  halted_o         out  1         arbiter is in HALT
// BEHAVIOUR
//  Reset: every output register is 0, the FSM is in EMPTY, and last_grant is 1 (r0 wins the first tie).
//  accept = (state==EMPTY) | (state==FULL & wbu_ready_i & ~ebreak_o); never in HALT.
//  Grant when accept is high:
//   - only one requester valid -> that requester wins;
//   - both valid -> the requester != last_grant wins.
//  rN_ready_o = accept & grant==N. Combinational; does not depend on rN_valid_i of the loser.
//  On handshake: capture the winner's fields into the output stage, set grant_o = N and last_grant = N.
//  The stage updates only on handshake; otherwise the held packet is stable while out_valid_o & ~wbu_ready_i.
//  Latency: 1 cycle from handshake to out_valid_o. Throughput is 1 packet/cycle with no bubble when wbu_ready_i=1.
//  x0 rule: wd_o = captured wd & (captured wreg != 0). wreg_o and wdata_o are passed through unchanged.
//  FSM:
//   EMPTY -> FULL  on handshake
//   FULL  -> FULL  on wbu_ready_i & new handshake (non-ebreak held packet)
//   FULL  -> EMPTY on wbu_ready_i & no new valid
//   FULL  -> HALT  on wbu_ready_i & ebreak_o; no packet is accepted in the same cycle
//   HALT  -> HALT  until reset; out_valid_o=0, rN_ready_o=0, halted_o=1
//  While an ebreak packet is held, both ready outputs stay 0, so no younger packet enters behind it.
//  Reset asserted mid-operation discards the held packet immediately, asynchronously. No partial write is emitted.
//  out_valid_o is state==FULL. Output fields are don't-care when out_valid_o=0 but are held, not cleared.
//  Requesters must hold their valid and data stable until ready; this is assumed by the bench and checked by assertion.
// TESTING
//  - Reset: release reset with both valid -> r0_ready_o=1 first cycle, grant_o=0 next cycle, halted_o=0.
//  - Round-robin: both valid for 4 cycles, wbu_ready_i=1 -> grants 0,1,0,1 with out_valid_o=1 every cycle after the first.
//  - Backpressure: r1 packet wreg=5/wdata=0xDEADBEEF, wbu_ready_i=0 for 3 cycles -> output stable, r0/r1 ready=0; release -> consumed once.
//  - x0: r0 wd=1, wreg=0, wdata=0x1234 -> wd_o=0, wdata_o=0x1234.
//  - Ebreak: r1 ebreak with r0 valid behind it -> r0_ready_o=0 while held; after consume halted_o=1 and out_valid_o=0 forever.
//  - Async reset mid-FULL (wbu_ready_i=0): reset low between clock edges -> out_valid_o=0 immediately, no handshake.

Source files
------------

// File: rtl/ysyx_23060025_wb_arbiter.sv
// Writeback arbiter: two producers share one GPR/CSR writeback port.
// Round-robin grant into a 1-entry output stage; halts after ebreak retires.
module ysyx_23060025_wb_arbiter #(
  parameter int DATA_LEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                r0_valid_i,
  output logic                r0_ready_o,
  input  logic                r0_wd_i,
  input  logic [4:0]          r0_wreg_i,
  input  logic [DATA_LEN-1:0] r0_wdata_i,
  input  logic [2:0]          r0_csr_type_i,
  input  logic [11:0]         r0_csr_waddr_i,
  input  logic [DATA_LEN-1:0] r0_csr_wdata_i,
  input  logic                r0_ebreak_i,
  input  logic                r1_valid_i,
  output logic                r1_ready_o,
  input  logic                r1_wd_i,
  input  logic [4:0]          r1_wreg_i,
  input  logic [DATA_LEN-1:0] r1_wdata_i,
  input  logic [2:0]          r1_csr_type_i,
  input  logic [11:0]         r1_csr_waddr_i,
  input  logic [DATA_LEN-1:0] r1_csr_wdata_i,
  input  logic                r1_ebreak_i,
  output logic                out_valid_o,
  input  logic                wbu_ready_i,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic [2:0]          csr_type_o,
  output logic [11:0]         csr_waddr_o,
  output logic [DATA_LEN-1:0] csr_wdata_o,
  output logic                ebreak_o,
  output logic                grant_o,
  output logic                halted_o
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FULL,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                r_last;
  logic                r_grant;
  logic                r_wd;
  logic [4:0]          r_wreg;
  logic [DATA_LEN-1:0] r_wdata;
  logic [2:0]          r_csr_type;
  logic [11:0]         r_csr_waddr;
  logic [DATA_LEN-1:0] r_csr_wdata;
  logic                r_ebreak;

  logic w_accept;
  logic w_gnt;
  logic w_hs;

  // Accept/grant: a held ebreak blocks everything behind it.
  always_comb begin
    w_accept = (r_state == S_EMPTY) |
               ((r_state == S_FULL) & wbu_ready_i & ~r_ebreak);
    w_gnt    = ~r_last;
    if (r0_valid_i & r1_valid_i) begin
      w_gnt = ~r_last;
    end else if (r1_valid_i) begin
      w_gnt = 1'b1;
    end else if (r0_valid_i) begin
      w_gnt = 1'b0;
    end
    w_hs = w_accept & (w_gnt ? r1_valid_i : r0_valid_i);
  end

  assign r0_ready_o = w_accept & ~w_gnt;
  assign r1_ready_o = w_accept & w_gnt;

  // State register; reset drops any held packet at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: ebreak consumption parks the arbiter until reset.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: begin
        if (w_hs) begin
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (wbu_ready_i) begin
          if (r_ebreak) begin
            w_state_nxt = S_HALT;
          end else if (w_hs) begin
            w_state_nxt = S_FULL;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Output stage: capture the winner only on handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last      <= 1'b1;
      r_grant     <= 1'b0;
      r_wd        <= 1'b0;
      r_wreg      <= '0;
      r_wdata     <= '0;
      r_csr_type  <= '0;
      r_csr_waddr <= '0;
      r_csr_wdata <= '0;
      r_ebreak    <= 1'b0;
    end else if (w_hs) begin
      r_last      <= w_gnt;
      r_grant     <= w_gnt;
      r_wd        <= w_gnt ? r1_wd_i        : r0_wd_i;
      r_wreg      <= w_gnt ? r1_wreg_i      : r0_wreg_i;
      r_wdata     <= w_gnt ? r1_wdata_i     : r0_wdata_i;
      r_csr_type  <= w_gnt ? r1_csr_type_i  : r0_csr_type_i;
      r_csr_waddr <= w_gnt ? r1_csr_waddr_i : r0_csr_waddr_i;
      r_csr_wdata <= w_gnt ? r1_csr_wdata_i : r0_csr_wdata_i;
      r_ebreak    <= w_gnt ? r1_ebreak_i    : r0_ebreak_i;
    end
  end

  assign out_valid_o = (r_state == S_FULL);
  assign halted_o    = (r_state == S_HALT);
  assign wd_o        = r_wd & (|r_wreg);
  assign wreg_o      = r_wreg;
  assign wdata_o     = r_wdata;
  assign csr_type_o  = r_csr_type;
  assign csr_waddr_o = r_csr_waddr;
  assign csr_wdata_o = r_csr_wdata;
  assign ebreak_o    = r_ebreak;
  assign grant_o     = r_grant;

endmodule

// File: tb/tb_ysyx_23060025_wb_arbiter.sv
// Bench for ysyx_23060025_wb_arbiter: directed cases plus random traffic
// checked against a queue-based model of the output stage.
module tb_ysyx_23060025_wb_arbiter;

  typedef struct packed {
    logic        wd;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [2:0]  csr_type;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        ebreak;
  } pkt_t;

  logic clock = 1'b0;
  logic reset;
  logic r0_valid_i, r1_valid_i, wbu_ready_i;
  pkt_t p0, p1;
  logic r0_ready_o, r1_ready_o, out_valid_o;
  logic wd_o, ebreak_o, grant_o, halted_o;
  logic [4:0]  wreg_o;
  logic [31:0] wdata_o, csr_wdata_o;
  logic [2:0]  csr_type_o;
  logic [11:0] csr_waddr_o;

  int n_cmp = 0;
  int n_bad = 0;

  pkt_t q[$];
  bit   m_halt, m_last, m_grant;
  bit   g_hs0, g_hs1;

  always #5 clock = ~clock;

  ysyx_23060025_wb_arbiter #(.DATA_LEN(32)) dut (
    .clock(clock), .reset(reset),
    .r0_valid_i(r0_valid_i), .r0_ready_o(r0_ready_o),
    .r0_wd_i(p0.wd), .r0_wreg_i(p0.wreg), .r0_wdata_i(p0.wdata),
    .r0_csr_type_i(p0.csr_type), .r0_csr_waddr_i(p0.csr_waddr),
    .r0_csr_wdata_i(p0.csr_wdata), .r0_ebreak_i(p0.ebreak),
    .r1_valid_i(r1_valid_i), .r1_ready_o(r1_ready_o),
    .r1_wd_i(p1.wd), .r1_wreg_i(p1.wreg), .r1_wdata_i(p1.wdata),
    .r1_csr_type_i(p1.csr_type), .r1_csr_waddr_i(p1.csr_waddr),
    .r1_csr_wdata_i(p1.csr_wdata), .r1_ebreak_i(p1.ebreak),
    .out_valid_o(out_valid_o), .wbu_ready_i(wbu_ready_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .csr_type_o(csr_type_o), .csr_waddr_o(csr_waddr_o),
    .csr_wdata_o(csr_wdata_o), .ebreak_o(ebreak_o),
    .grant_o(grant_o), .halted_o(halted_o)
  );

  a_hold0: assert property (@(posedge clock) disable iff (!reset)
    (r0_valid_i && !r0_ready_o) |=> (r0_valid_i && $stable(p0)))
    else $error("FAIL hold0: r0 dropped or changed before ready");
  a_hold1: assert property (@(posedge clock) disable iff (!reset)
    (r1_valid_i && !r1_ready_o) |=> (r1_valid_i && $stable(p1)))
    else $error("FAIL hold1: r1 dropped or changed before ready");

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic pkt_t rnd_pkt(input bit allow_eb);
    pkt_t p;
    p.wd        = 1'($urandom);
    p.wreg      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    p.wdata     = $urandom;
    p.csr_type  = 3'($urandom);
    p.csr_waddr = 12'($urandom);
    p.csr_wdata = $urandom;
    p.ebreak    = allow_eb && ($urandom_range(0, 31) == 0);
    return p;
  endfunction

  task automatic model_reset();
    q.delete();
    m_halt  = 1'b0;
    m_last  = 1'b1;
    m_grant = 1'b0;
  endtask

  task automatic chk_out();
    chk("oval", out_valid_o, q.size() == 1);
    chk("halt", halted_o, m_halt);
    if (q.size() == 1) begin
      chk("wd", wd_o, q[0].wd && (q[0].wreg != 0));
      chk("wreg", wreg_o, q[0].wreg);
      chk("wdata", wdata_o, q[0].wdata);
      chk("csrt", csr_type_o, q[0].csr_type);
      chk("csra", csr_waddr_o, q[0].csr_waddr);
      chk("csrd", csr_wdata_o, q[0].csr_wdata);
      chk("ebrk", ebreak_o, q[0].ebreak);
      chk("gnt", grant_o, m_grant);
    end
  endtask

  // One cycle: drive just after negedge, check readies, advance model,
  // then check registered outputs at the next negedge.
  task automatic step(input bit v0, input pkt_t a, input bit v1,
                      input pkt_t b, input bit wr);
    bit acc, w, hs;
    pkt_t h;
    r0_valid_i  = v0;
    p0          = a;
    r1_valid_i  = v1;
    p1          = b;
    wbu_ready_i = wr;
    #1;
    acc = !m_halt && (q.size() == 0 || (wr && !q[0].ebreak));
    w   = (v0 && v1) ? !m_last : v1;
    hs  = acc && (v0 || v1);
    chk("hs0", r0_valid_i & r0_ready_o, hs && !w);
    chk("hs1", r1_valid_i & r1_ready_o, hs && w);
    if (!acc) begin
      chk("blk0", r0_ready_o, 0);
      chk("blk1", r1_ready_o, 0);
    end
    g_hs0 = hs && !w;
    g_hs1 = hs && w;
    if (q.size() != 0 && wr) begin
      h = q.pop_front();
      if (h.ebreak) m_halt = 1'b1;
    end
    if (hs) begin
      q.push_back(w ? b : a);
      m_last  = w;
      m_grant = w;
    end
    @(negedge clock);
    chk_out();
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    r0_valid_i = 1'b0;
    r1_valid_i = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    pkt_t z, pa, pb, bp, xp, eb;
    bit [3:0] exp_g;
    bit pv0, pv1;
    pkt_t pp0, pp1;
    int hc;
    z = '0;
    reset = 1'b0;
    r0_valid_i = 1'b0;
    r1_valid_i = 1'b0;
    wbu_ready_i = 1'b0;
    p0 = '0;
    p1 = '0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_oval", out_valid_o, 0);
    chk("rst_halt", halted_o, 0);
    chk("rst_gnt0", grant_o, 0);
    chk("rst_wd", wd_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_ebrk", ebreak_o, 0);

    // reset release with both valid, then round-robin
    reset = 1'b1;
    pa = rnd_pkt(0);
    pb = rnd_pkt(0);
    r0_valid_i = 1'b1;
    r1_valid_i = 1'b1;
    p0 = pa;
    p1 = pb;
    #1;
    chk("rst_r0rdy", r0_ready_o, 1);
    exp_g = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step(1, pa, 1, pb, 1);
      chk("rr_gnt", grant_o, exp_g[i]);
      chk("rr_oval", out_valid_o, 1);
      chk("rr_halt", halted_o, 0);
      if (g_hs0) pa = rnd_pkt(0);
      if (g_hs1) pb = rnd_pkt(0);
    end
    step(1, pa, 0, z, 1);
    step(0, z, 0, z, 1);

    // backpressure
    bp = rnd_pkt(0);
    bp.wreg = 5'd5;
    bp.wdata = 32'hDEADBEEF;
    step(0, z, 1, bp, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, z, 0, z, 0);
      chk("bp_wdata", wdata_o, 32'hDEADBEEF);
      chk("bp_wreg", wreg_o, 5);
      chk("bp_oval", out_valid_o, 1);
      chk("bp_rdy0", r0_ready_o, 0);
      chk("bp_rdy1", r1_ready_o, 0);
    end
    step(0, z, 0, z, 1);
    chk("bp_gone", out_valid_o, 0);
    step(0, z, 0, z, 1);
    chk("bp_once", out_valid_o, 0);

    // x0 write suppression
    xp = rnd_pkt(0);
    xp.wd = 1'b1;
    xp.wreg = 5'd0;
    xp.wdata = 32'h1234;
    step(1, xp, 0, z, 1);
    chk("x0_wd", wd_o, 0);
    chk("x0_wdata", wdata_o, 32'h1234);
    step(0, z, 0, z, 1);

    // ebreak halts everything behind it
    eb = rnd_pkt(0);
    eb.ebreak = 1'b1;
    pa = rnd_pkt(0);
    step(0, z, 1, eb, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, pa, 0, z, 0);
      chk("eb_rdy0", r0_ready_o, 0);
    end
    step(1, pa, 0, z, 1);
    chk("eb_halt", halted_o, 1);
    chk("eb_oval", out_valid_o, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, pa, 0, z, 1);
      chk("eb_stay", out_valid_o, 0);
      chk("eb_rdy0h", r0_ready_o, 0);
      chk("eb_halth", halted_o, 1);
    end
    do_reset();

    // asynchronous reset while FULL and stalled
    pa = rnd_pkt(0);
    pb = rnd_pkt(0);
    step(1, pa, 0, z, 0);
    step(1, pb, 0, z, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_oval", out_valid_o, 0);
    chk("arst_halt", halted_o, 0);
    model_reset();
    @(negedge clock);
    chk("arst_hold", out_valid_o, 0);
    r0_valid_i = 1'b0;
    reset = 1'b1;

    // random traffic
    pv0 = 0;
    pv1 = 0;
    pp0 = z;
    pp1 = z;
    hc = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!pv0 && $urandom_range(0, 9) < 6) begin
        pv0 = 1;
        pp0 = rnd_pkt(1);
      end
      if (!pv1 && $urandom_range(0, 9) < 6) begin
        pv1 = 1;
        pp1 = rnd_pkt(1);
      end
      step(pv0, pp0, pv1, pp1, $urandom_range(0, 9) < 7);
      if (g_hs0) pv0 = 0;
      if (g_hs1) pv1 = 0;
      if (m_halt) hc++;
      if (hc > 4) begin
        do_reset();
        pv0 = 0;
        pv1 = 0;
        hc = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
